pattern_sweep_checker: RTL and testbench

- Sequential successor to the team's exhaustive 4-input gate-function benches.
- Sweeps every input vector of a WIDTH-input combinational DUT, holds each vector for DWELL cycles and samples the 1-bit DUT output.
- Compares each sample against a golden truth table and folds all samples into a signature.
- Inserts a programmable idle gap between the lower and upper halves of the input space, so the half-boundary transition can be observed.

---
 rtl/sweep_pkg.sv | 22 ++
 rtl/sweep_misr.sv | 36 +++
 rtl/pattern_sweep_checker.sv | 163 ++++++++++++++++
 tb/tb_pattern_sweep_checker.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Purpose: shared state encoding, default signature polynomial and counter sizing for the sweep checker.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;

    // Width of the shared dwell/gap counter: it must count 0..max(dwell,gap)-1.
    function automatic int cnt_width(input int dwell, input int gap);
        int m;
        m = (dwell > gap) ? dwell : gap;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sweep_misr.sv
// Purpose: serial signature register folding one sample bit per enabled cycle.
// Latency: signature reflects a sample one cycle after en is high.
// Backpressure: none; clr has priority over en, reset over both.
// Ports: clk, rst_n (sync, active-low), clr (zero the signature), en (fold din), din (sample bit), sig (signature).
module sweep_misr
    import sweep_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_fb;

    assign w_fb = r_sig[SIG_W-1] ? POLY : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ w_fb ^ {{(SIG_W-1){1'b0}}, din};
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/pattern_sweep_checker.sv
// Purpose: drives every input vector of a WIDTH-input combinational DUT, checks each sampled output against a latched truth table and signs all samples.
// Latency: sweep occupies 2**WIDTH*DWELL + GAP busy cycles after an accepted start; done rises the cycle after the final sample.
// Backpressure: start is accepted only in IDLE or DONE and ignored while busy; no other flow control.
// Ports: clk, rst_n (sync, active-low), start (one-cycle request), exp_table (golden table, bit k = vector k),
//        dut_in/dut_out (stimulus/response), busy, done, pass, err_cnt, first_fail, sig (results).
// Build option: define SWEEP_GRAY_EN to drive vectors in Gray order (table lookup and first_fail use the Gray value).
module pattern_sweep_checker
    import sweep_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter int               DWELL = 5,
    parameter int               GAP   = 12,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2**WIDTH-1:0]   exp_table,
    output logic [WIDTH-1:0]      dut_in,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [WIDTH:0]        err_cnt,
    output logic [WIDTH-1:0]      first_fail,
    output logic [SIG_W-1:0]      sig
);

    localparam int               CNT_W     = cnt_width(DWELL, GAP);
    localparam logic [WIDTH-1:0] VEC_LAST  = '1;
    localparam logic [WIDTH-1:0] HALF_LAST = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam bit               HAS_GAP   = (GAP > 0);

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_vec;
    logic [WIDTH-1:0]     r_dut_in;
    logic [2**WIDTH-1:0]  r_table;
    logic [CNT_W-1:0]     r_dwell;
    logic [WIDTH:0]       r_err;
    logic [WIDTH-1:0]     r_ff;

    logic w_start_acc;
    logic w_sample;
    logic w_step;
    logic w_busy;
    logic w_done;
    logic w_mismatch;

    // Sweep-step index to the value actually presented to the DUT.
    function automatic logic [WIDTH-1:0] to_code(input logic [WIDTH-1:0] v);
`ifdef SWEEP_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // r_dut_in always holds the coded vector, so it doubles as the table index.
    assign w_mismatch = (dut_out != r_table[r_dut_in]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_sample = 1'b0;
        w_step   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_DRIVE;
            end
            ST_DRIVE: begin
                w_busy = 1'b1;
                if (r_dwell == DWELL_END) begin
                    w_sample = 1'b1;
                    if (r_vec == VEC_LAST) begin
                        w_next = ST_DONE;
                    end else if (HAS_GAP && (r_vec == HALF_LAST)) begin
                        w_next = ST_GAP;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                w_busy = 1'b1;
                if (r_dwell == GAP_END) begin
                    w_next = ST_DRIVE;
                    w_step = 1'b1;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (start) w_next = ST_DRIVE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_table  <= '0;
            r_vec    <= '0;
            r_dut_in <= '0;
            r_dwell  <= '0;
            r_err    <= '0;
            r_ff     <= '0;
        end else if (w_start_acc) begin
            r_table  <= exp_table;
            r_vec    <= '0;
            r_dut_in <= to_code('0);
            r_dwell  <= '0;
            r_err    <= '0;
            r_ff     <= '0;
        end else begin
            if (w_sample && w_mismatch) begin
                r_err <= r_err + 1'b1;
                if (r_err == '0) r_ff <= r_dut_in;
            end
            if (w_step) begin
                r_vec    <= r_vec + 1'b1;
                r_dut_in <= to_code(r_vec + 1'b1);
                r_dwell  <= '0;
            end else if (w_busy) begin
                // The same counter times the dwell and, after the half-way sample, the gap.
                r_dwell <= w_sample ? '0 : r_dwell + 1'b1;
            end
        end
    end

    sweep_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start_acc),
        .en    (w_sample),
        .din   (dut_out),
        .sig   (sig)
    );

    assign dut_in     = r_dut_in;
    assign busy       = w_busy;
    assign done       = w_done;
    assign pass       = w_done && (r_err == '0);
    assign err_cnt    = r_err;
    assign first_fail = r_ff;

endmodule

// File: tb/tb_pattern_sweep_checker.sv
// Purpose: randomized self-checking bench for pattern_sweep_checker against a sweep-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pattern_sweep_checker;

    localparam int W   = 4;
    localparam int DW  = 5;
    localparam int GP  = 12;
    localparam int SW  = 16;
    localparam int NV  = 1 << W;
    localparam int W2  = 3;
    localparam int NV2 = 1 << W2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            start;
    logic [NV-1:0]   exp_table;
    logic [W-1:0]    dut_in;
    logic            dut_out;
    logic            busy, done, pass;
    logic [W:0]      err_cnt;
    logic [W-1:0]    first_fail;
    logic [SW-1:0]   sig;
    logic [NV-1:0]   dut_fn;

    logic            s_start;
    logic [NV2-1:0]  s_table;
    logic [W2-1:0]   s_dut_in;
    logic            s_dut_out;
    logic            s_busy, s_done, s_pass;
    logic [W2:0]     s_err_cnt;
    logic [W2-1:0]   s_first_fail;
    logic [SW-1:0]   s_sig;
    logic [NV2-1:0]  s_fn;

    // Combinational DUTs under test are plain truth tables.
    assign dut_out   = dut_fn[dut_in];
    assign s_dut_out = s_fn[s_dut_in];

    pattern_sweep_checker #(.WIDTH(W), .DWELL(DW), .GAP(GP), .SIG_W(SW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .exp_table(exp_table),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail(first_fail), .sig(sig)
    );

    pattern_sweep_checker #(.WIDTH(W2), .DWELL(1), .GAP(0), .SIG_W(SW)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .exp_table(s_table),
        .dut_in(s_dut_in), .dut_out(s_dut_out), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_cnt(s_err_cnt), .first_fail(s_first_fail), .sig(s_sig)
    );

    int checks   = 0;
    int failures = 0;

    int          q0[$];
    int          q1[$];
    int          e_err[2];
    int          e_ff[2];
    logic [15:0] e_sig[2];
    bit          mon[2];
    int          cyc[2];
    logic [SW-1:0] sig_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int code(input int v);
`ifdef SWEEP_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    // Whole-sweep expectation: one queue entry per busy cycle, plus final results.
    task automatic model(input int id, input int w, input int dwell, input int gap,
                         input logic [15:0] tbl, input logic [15:0] fn);
        int nv;
        int half;
        int err;
        int ff;
        int c;
        logic b;
        logic [15:0] s;
        nv   = 1 << w;
        half = (1 << (w - 1)) - 1;
        err  = 0;
        ff   = 0;
        s    = 16'h0;
        if (id == 0) q0.delete(); else q1.delete();
        for (int v = 0; v < nv; v++) begin
            c = code(v);
            for (int k = 0; k < dwell + ((v == half) ? gap : 0); k++) begin
                if (id == 0) q0.push_back(c); else q1.push_back(c);
            end
            b = fn[c];
            if (b != tbl[c]) begin
                if (err == 0) ff = c;
                err++;
            end
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
        end
        e_err[id] = err;
        e_ff[id]  = ff;
        e_sig[id] = s;
    endtask

    // Compare process: per busy cycle check the driven vector, then the results when done rises.
    always @(negedge clk) begin
        logic [31:0] act;
        logic [31:0] req;
        if (mon[0]) begin
            cyc[0]++;
            if (cyc[0] <= q0.size()) begin
                act = 32'h0; act[5] = busy; act[4] = done; act[3:0] = dut_in;
                req = 32'h20 | q0[cyc[0]-1];
                check("drive0", act, req);
            end else begin
                check("done0", {30'b0, busy, done}, 32'd1);
                check("err0", {27'b0, err_cnt}, e_err[0]);
                check("ff0", {28'b0, first_fail}, e_ff[0]);
                check("sig0", {16'b0, sig}, {16'b0, e_sig[0]});
                check("pass0", {31'b0, pass}, (e_err[0] == 0) ? 32'd1 : 32'd0);
                mon[0] = 1'b0;
            end
        end
        if (mon[1]) begin
            cyc[1]++;
            if (cyc[1] <= q1.size()) begin
                act = 32'h0; act[5] = s_busy; act[4] = s_done; act[2:0] = s_dut_in;
                req = 32'h20 | q1[cyc[1]-1];
                check("drive1", act, req);
            end else begin
                check("done1", {30'b0, s_busy, s_done}, 32'd1);
                check("err1", {28'b0, s_err_cnt}, e_err[1]);
                check("ff1", {29'b0, s_first_fail}, e_ff[1]);
                check("sig1", {16'b0, s_sig}, {16'b0, e_sig[1]});
                check("pass1", {31'b0, s_pass}, (e_err[1] == 0) ? 32'd1 : 32'd0);
                mon[1] = 1'b0;
            end
        end
    end

    task automatic wait_mon(input int id);
        for (int i = 0; i < 300 && mon[id]; i++) @(negedge clk);
        if (mon[id]) begin
            check("timeout", 32'd0, 32'd1);
            mon[id] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run0(input logic [15:0] tbl, input logic [15:0] fn, input bit poke);
        model(0, W, DW, GP, tbl, fn);
        dut_fn    = fn;
        exp_table = tbl;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        exp_table = 16'($urandom);   // table must already be latched
        cyc[0]    = 0;
        mon[0]    = 1'b1;
        if (poke) begin
            repeat (20) @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_mon(0);
    endtask

    task automatic run1(input logic [7:0] tbl, input logic [7:0] fn);
        model(1, W2, 1, 0, {8'h0, tbl}, {8'h0, fn});
        s_fn    = fn;
        s_table = tbl;
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        cyc[1]  = 0;
        mon[1]  = 1'b1;
        wait_mon(1);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        s_start   = 1'b0;
        exp_table = '0;
        dut_fn    = '0;
        s_table   = '0;
        s_fn      = '0;
        mon[0] = 1'b0; mon[1] = 1'b0;
        cyc[0] = 0;    cyc[1] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {busy, done, pass, dut_in, err_cnt, first_fail, sig}, 32'h0);
        check("reset_small", {21'b0, s_busy, s_done, s_pass, s_err_cnt, s_first_fail}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 4-input AND, matching table.
        run0(16'h8000, 16'h8000, 1'b0);
        check("model_len", q0.size(), 32'd92);
        check("model_and_err", e_err[0], 32'd0);
        check("and_pass", {31'b0, pass}, 32'd1);
        check("and_err", {27'b0, err_cnt}, 32'd0);
        sig_a = sig;

        // Same DUT, table wrong at vector 0.
        run0(16'h8001, 16'h8000, 1'b0);
        check("tbl_err", {27'b0, err_cnt}, 32'd1);
        check("tbl_ff", {28'b0, first_fail}, 32'd0);
        check("tbl_pass", {31'b0, pass}, 32'd0);
        check("sig_same", {16'b0, sig}, {16'b0, sig_a});

        // Stuck-at-1 DUT against an all-zero table.
        run0(16'h0000, 16'hFFFF, 1'b0);
        check("model_sa1_err", e_err[0], 32'd16);
        check("sa1_err", {27'b0, err_cnt}, 32'd16);
        check("sa1_ff", {28'b0, first_fail}, 32'd0);

        // start pulsed mid-sweep must be ignored; length is still checked per cycle.
        run0(16'($urandom), 16'($urandom), 1'b1);

        // Reset in the middle of a sweep.
        dut_fn    = 16'hFFFF;
        exp_table = 16'h0000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid", {5'b0, busy, done, dut_in, err_cnt, sig}, 32'h0);
        run0(16'($urandom), 16'($urandom), 1'b0);

        // Reset and start together: reset wins.
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("rst_vs_start", {25'b0, busy, done, err_cnt}, 32'h0);

        for (int r = 0; r < 3; r++) run0(16'($urandom), 16'($urandom), 1'b0);

        // Small instance: DWELL=1, GAP=0.
        run1(8'h80, 8'h80);
`ifdef SWEEP_GRAY_EN
        check("model_seq4", q1[4], 32'd6);
`else
        check("model_seq4", q1[4], 32'd4);
`endif
        check("small_len", q1.size(), 32'd8);
        for (int r = 0; r < 2; r++) run1(8'($urandom), 8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
